// File: rtl/axi_rd_master_burst.sv
// AXI4 read master issuing one INCR burst per request.
//
// Accepts a single CPU/cache read request, issues one AR burst of 1..MAX_BEATS beats,
// gathers every R beat into a line buffer and presents a held response. For single-beat
// requests the datum is also right-aligned and zero- or sign-extended.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   req_*_i / req_ready_o request channel (one outstanding request)
//   rsp_*_o / rsp_ready_i response channel, held until accepted
//   ar*_o / arready_i     AXI read address channel
//   r*_i / rready_o       AXI read data channel
module axi_rd_master_burst #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MAX_BEATS = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  // Request
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ADDR_W-1:0]             req_addr_i,
  input  logic [ID_W-1:0]               req_id_i,
  input  logic [7:0]                    req_len_i,
  input  logic [2:0]                    req_size_i,
  input  logic                          req_signed_i,
  // Response
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [DATA_W-1:0]             rsp_data_o,
  output logic [MAX_BEATS*DATA_W-1:0]   rsp_line_o,
  output logic [1:0]                    rsp_resp_o,
  output logic                          rsp_err_o,
  // AXI AR
  output logic                          arvalid_o,
  input  logic                          arready_i,
  output logic [ID_W-1:0]               arid_o,
  output logic [ADDR_W-1:0]             araddr_o,
  output logic [7:0]                    arlen_o,
  output logic [2:0]                    arsize_o,
  output logic [1:0]                    arburst_o,
  // AXI R
  input  logic                          rvalid_i,
  output logic                          rready_o,
  input  logic [ID_W-1:0]               rid_i,
  input  logic [DATA_W-1:0]             rdata_i,
  input  logic [1:0]                    rresp_i,
  input  logic                          rlast_i
);

  localparam int unsigned Bytes = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned CntW  = $clog2(MAX_BEATS + 1);

  localparam logic [2:0]      BusSize = 3'(OffW);
  localparam logic [7:0]      MaxLen  = 8'(MAX_BEATS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_BEATS);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [ID_W-1:0]                   id_q, id_d;
  logic [7:0]                        arlen_q, arlen_d;
  logic [2:0]                        arsize_q, arsize_d;
  logic [2:0]                        size_q, size_d;
  logic                              signed_q, signed_d;
  logic                              burst_q, burst_d;
  logic [CntW-1:0]                   cnt_q, cnt_d;
  logic [MAX_BEATS-1:0][DATA_W-1:0]  line_q, line_d;
  logic [1:0]                        resp_q, resp_d;
  logic                              err_q, err_d;

  logic [31:0]                       span;
  logic [7:0]                        beat_idx;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid_i)           state_d = StAddr;
      StAddr: if (arready_i)             state_d = StData;
      StData: if (rvalid_i && rlast_i)   state_d = StResp;
      StResp: if (rsp_ready_i)           state_d = StIdle;
      default:                           state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready_o = (state_q == StIdle);
    arvalid_o   = (state_q == StAddr);
    rready_o    = (state_q == StData);
    rsp_valid_o = (state_q == StResp);
    arburst_o   = (state_q == StAddr) ? 2'b01 : 2'b00;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Bytes touched by a single-beat access measured from the start of the bus word.
  assign span     = 32'(req_addr_i[OffW-1:0]) + (32'd1 << req_size_i);
  assign beat_idx = 8'(cnt_q);

  always_comb begin
    addr_d   = addr_q;
    id_d     = id_q;
    arlen_d  = arlen_q;
    arsize_d = arsize_q;
    size_d   = size_q;
    signed_d = signed_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    line_d   = line_q;
    resp_d   = resp_q;
    err_d    = err_q;

    if (state_q == StIdle && req_valid_i) begin
      addr_d   = req_addr_i;
      id_d     = req_id_i;
      size_d   = req_size_i;
      signed_d = req_signed_i;
      burst_d  = (req_len_i != 8'd0);
      arlen_d  = (32'(req_len_i) >= MAX_BEATS) ? MaxLen : req_len_i;
      arsize_d = (req_len_i != 8'd0) ? BusSize : req_size_i;
      cnt_d    = '0;
      resp_d   = 2'b00;
      err_d    = (32'(req_len_i) >= MAX_BEATS) ||
                 ((req_len_i == 8'd0) && (span > 32'(Bytes)));
    end

    if (state_q == StData && rvalid_i) begin
      // Beats beyond the buffer depth are dropped but still checked.
      for (int unsigned k = 0; k < MAX_BEATS; k++) begin
        if (cnt_q == CntW'(k)) line_d[k] = rdata_i;
      end
      if (cnt_q < CntMax) cnt_d = cnt_q + 1'b1;
      if (rresp_i > resp_q) resp_d = rresp_i;
      if (rid_i != id_q) err_d = 1'b1;
      if (rlast_i && (beat_idx != arlen_q)) err_d = 1'b1;
      if (!rlast_i && (beat_idx > arlen_q)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q   <= '0;
      id_q     <= '0;
      arlen_q  <= '0;
      arsize_q <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      burst_q  <= 1'b0;
      cnt_q    <= '0;
      line_q   <= '0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      id_q     <= id_d;
      arlen_q  <= arlen_d;
      arsize_q <= arsize_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
    end
  end

  // AR channel driven straight from captured request fields so they stay stable while stalled.
  assign arid_o   = id_q;
  assign araddr_o = {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}};
  assign arlen_o  = arlen_q;
  assign arsize_o = arsize_q;

  assign rsp_line_o = line_q;
  assign rsp_resp_o = resp_q;
  assign rsp_err_o  = err_q;

  // ---------------------------------------------------------------------------
  // Single-beat extraction from beat 0
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] top_bit;
  int unsigned       nbits;
  logic              sign;

  always_comb begin
    shifted = line_q[0] >> {addr_q[OffW-1:0], 3'b000};
    // Accesses wider than the bus keep only the in-word bytes.
    nbits   = (32'(size_q) >= OffW) ? DATA_W : (32'd8 << size_q);
    top_bit = {{(DATA_W-1){1'b0}}, 1'b1} << (nbits - 1);
    sign    = signed_q && ((shifted & top_bit) != '0);
    rsp_data_o = line_q[0];
    if (!burst_q) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        rsp_data_o[i] = (i < nbits) ? shifted[i] : sign;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_master_burst.sv
// Directed self-checking bench for axi_rd_master_burst (DATA_W=64, MAX_BEATS=8).
module tb_axi_rd_master_burst;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned ID_W      = 4;
  localparam int unsigned MAX_BEATS = 8;

  logic                        clk = 1'b0;
  logic                        reset_n = 1'b0;
  logic                        req_valid = 1'b0;
  logic                        req_ready;
  logic [ADDR_W-1:0]           req_addr = '0;
  logic [ID_W-1:0]             req_id = '0;
  logic [7:0]                  req_len = '0;
  logic [2:0]                  req_size = '0;
  logic                        req_signed = 1'b0;
  logic                        rsp_valid;
  logic                        rsp_ready = 1'b0;
  logic [DATA_W-1:0]           rsp_data;
  logic [MAX_BEATS*DATA_W-1:0] rsp_line;
  logic [1:0]                  rsp_resp;
  logic                        rsp_err;
  logic                        arvalid;
  logic                        arready = 1'b0;
  logic [ID_W-1:0]             arid;
  logic [ADDR_W-1:0]           araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        rvalid = 1'b0;
  logic                        rready;
  logic [ID_W-1:0]             rid = '0;
  logic [DATA_W-1:0]           rdata = '0;
  logic [1:0]                  rresp = '0;
  logic                        rlast = 1'b0;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [MAX_BEATS*DATA_W-1:0] exp_line;

  axi_rd_master_burst #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_id_i     (req_id),
    .req_len_i    (req_len),
    .req_size_i   (req_size),
    .req_signed_i (req_signed),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_line_o   (rsp_line),
    .rsp_resp_o   (rsp_resp),
    .rsp_err_o    (rsp_err),
    .arvalid_o    (arvalid),
    .arready_i    (arready),
    .arid_o       (arid),
    .araddr_o     (araddr),
    .arlen_o      (arlen),
    .arsize_o     (arsize),
    .arburst_o    (arburst),
    .rvalid_i     (rvalid),
    .rready_o     (rready),
    .rid_i        (rid),
    .rdata_i      (rdata),
    .rresp_i      (rresp),
    .rlast_i      (rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && req_ready !== 1'b1; i++) tick();
    check_eq("wait_idle", 512'(req_ready), 512'(1));
  endtask

  task automatic send_req(input logic [63:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic sgn);
    wait_idle();
    req_valid  = 1'b1;
    req_addr   = addr;
    req_id     = id;
    req_len    = len;
    req_size   = size;
    req_signed = sgn;
    tick();
    req_valid  = 1'b0;
  endtask

  task automatic ar_accept(input int delay, input logic [63:0] exp_addr);
    for (int d = 0; d < delay; d++) begin
      check_eq("ar_hold_valid", 512'(arvalid), 512'(1));
      check_eq("ar_hold_addr", 512'(araddr), 512'(exp_addr));
      tick();
    end
    check_eq("ar_valid", 512'(arvalid), 512'(1));
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("rready_up", 512'(rready), 512'(1));
  endtask

  task automatic beat(input logic [63:0] data, input logic [3:0] id, input logic [1:0] resp,
                      input logic last);
    rvalid = 1'b1;
    rdata  = data;
    rid    = id;
    rresp  = resp;
    rlast  = last;
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  task automatic finish_rsp();
    check_eq("rsp_valid_held", 512'(rsp_valid), 512'(1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("idle_after_rsp", 512'(req_ready), 512'(1));
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check_eq("rst_req_ready", 512'(req_ready), 512'(1));
    check_eq("rst_arvalid", 512'(arvalid), 512'(0));
    check_eq("rst_rready", 512'(rready), 512'(0));
    check_eq("rst_rsp_valid", 512'(rsp_valid), 512'(0));
    check_eq("rst_line", 512'(rsp_line), 512'(0));
    check_eq("rst_err", 512'(rsp_err), 512'(0));
    reset_n = 1'b1;
    tick();

    // Single signed word load at offset 4
    send_req(64'h8000_0004, 4'd1, 8'd0, 3'd2, 1'b1);
    check_eq("ld_araddr", 512'(araddr), 512'(64'h8000_0000));
    check_eq("ld_arlen", 512'(arlen), 512'(0));
    check_eq("ld_arsize", 512'(arsize), 512'(2));
    check_eq("ld_arburst", 512'(arburst), 512'(1));
    check_eq("ld_arid", 512'(arid), 512'(1));
    check_eq("ld_req_ready", 512'(req_ready), 512'(0));
    ar_accept(0, 64'h8000_0000);
    beat(64'h8765_4321_0000_0000, 4'd1, 2'd0, 1'b1);
    check_eq("ld_rsp_valid", 512'(rsp_valid), 512'(1));
    check_eq("ld_data", 512'(rsp_data), 512'(64'hFFFF_FFFF_8765_4321));
    check_eq("ld_err", 512'(rsp_err), 512'(0));
    check_eq("ld_resp", 512'(rsp_resp), 512'(0));
    finish_rsp();

    // 8-beat refill with delayed arready
    send_req(64'h8000_0040, 4'd3, 8'd7, 3'd3, 1'b0);
    check_eq("refill_arlen", 512'(arlen), 512'(7));
    check_eq("refill_arsize", 512'(arsize), 512'(3));
    ar_accept(3, 64'h8000_0040);
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      check_eq("refill_no_rsp_yet", 512'(rsp_valid), 512'(0));
      beat(64'(k), 4'd3, 2'd0, k == 7);
      exp_line[k*DATA_W +: DATA_W] = 64'(k);
    end
    check_eq("refill_rsp_valid", 512'(rsp_valid), 512'(1));
    check_eq("refill_line", 512'(rsp_line), 512'(exp_line));
    check_eq("refill_data", 512'(rsp_data), 512'(0));
    check_eq("refill_err", 512'(rsp_err), 512'(0));
    finish_rsp();

    // Response merge: OKAY, SLVERR, OKAY, DECERR
    send_req(64'h100, 4'd4, 8'd3, 3'd3, 1'b0);
    ar_accept(0, 64'h100);
    beat(64'h10, 4'd4, 2'd0, 1'b0);
    beat(64'h11, 4'd4, 2'd2, 1'b0);
    beat(64'h12, 4'd4, 2'd0, 1'b0);
    beat(64'h13, 4'd4, 2'd3, 1'b1);
    check_eq("merge_resp", 512'(rsp_resp), 512'(3));
    check_eq("merge_err", 512'(rsp_err), 512'(0));
    finish_rsp();

    // Early rlast on beat 1 of 4
    send_req(64'h200, 4'd2, 8'd3, 3'd3, 1'b0);
    ar_accept(0, 64'h200);
    beat(64'h20, 4'd2, 2'd0, 1'b0);
    beat(64'h21, 4'd2, 2'd0, 1'b1);
    check_eq("early_last_resp_state", 512'(rsp_valid), 512'(1));
    check_eq("early_last_err", 512'(rsp_err), 512'(1));
    finish_rsp();

    // ID mismatch: rid=5 against id=2, beat still stored
    send_req(64'h200, 4'd2, 8'd0, 3'd3, 1'b0);
    ar_accept(0, 64'h200);
    beat(64'h55, 4'd5, 2'd0, 1'b1);
    check_eq("rid_err", 512'(rsp_err), 512'(1));
    check_eq("rid_data", 512'(rsp_data), 512'(64'h55));
    finish_rsp();

    // Response backpressure, signed byte at offset 0, EXOKAY
    send_req(64'h10, 4'd6, 8'd0, 3'd0, 1'b1);
    ar_accept(0, 64'h10);
    beat(64'h1122_3344_5566_7788, 4'd6, 2'd1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_valid", 512'(rsp_valid), 512'(1));
      check_eq("bp_data", 512'(rsp_data), 512'(64'hFFFF_FFFF_FFFF_FF88));
      check_eq("bp_resp", 512'(rsp_resp), 512'(1));
      check_eq("bp_req_ready", 512'(req_ready), 512'(0));
      tick();
    end
    finish_rsp();

    // Unsigned halfword at offset 3 (inside the word)
    send_req(64'h13, 4'd6, 8'd0, 3'd1, 1'b0);
    check_eq("half_arsize", 512'(arsize), 512'(1));
    ar_accept(0, 64'h10);
    beat(64'h1122_3344_5566_7788, 4'd6, 2'd0, 1'b1);
    check_eq("half_data", 512'(rsp_data), 512'(64'h4455));
    check_eq("half_err", 512'(rsp_err), 512'(0));
    finish_rsp();

    // Word at offset 6 crosses the bus word: in-word bytes only, error flagged
    send_req(64'h6, 4'd6, 8'd0, 3'd2, 1'b0);
    ar_accept(0, 64'h0);
    beat(64'h1122_3344_5566_7788, 4'd6, 2'd0, 1'b1);
    check_eq("cross_err", 512'(rsp_err), 512'(1));
    check_eq("cross_data", 512'(rsp_data), 512'(64'h1122));
    finish_rsp();

    // Reset in the middle of DATA
    send_req(64'h300, 4'd1, 8'd3, 3'd3, 1'b0);
    ar_accept(0, 64'h300);
    beat(64'hDEAD, 4'd1, 2'd0, 1'b0);
    reset_n = 1'b0;
    tick();
    check_eq("midrst_arvalid", 512'(arvalid), 512'(0));
    check_eq("midrst_rready", 512'(rready), 512'(0));
    check_eq("midrst_rsp_valid", 512'(rsp_valid), 512'(0));
    check_eq("midrst_req_ready", 512'(req_ready), 512'(1));
    check_eq("midrst_line", 512'(rsp_line), 512'(0));
    reset_n = 1'b1;
    tick();

    // Illegal length 20 clamps to 8 beats
    send_req(64'h1000, 4'd7, 8'd20, 3'd3, 1'b0);
    check_eq("illen_arlen", 512'(arlen), 512'(7));
    check_eq("illen_arsize", 512'(arsize), 512'(3));
    ar_accept(0, 64'h1000);
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      beat(64'(32'hA0 + k), 4'd7, 2'd0, k == 7);
      exp_line[k*DATA_W +: DATA_W] = 64'(32'hA0 + k);
    end
    check_eq("illen_rsp_valid", 512'(rsp_valid), 512'(1));
    check_eq("illen_err", 512'(rsp_err), 512'(1));
    check_eq("illen_line", 512'(rsp_line), 512'(exp_line));
    finish_rsp();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
